stream_pad_fifo: RTL and testbench
==================================

STREAM_PAD_FIFO -- requirements
Module: stream_pad_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of stream payload.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; must be a power of two and at least 2.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: sole clock; all logic is rising-edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream (DSP out_0) beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the upstream beat.
REQ-007 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-008 SHALL have port in_last, input, 1 bit: upstream end-of-frame marker.
REQ-009 SHALL have port pad_ready_i, input, 1 bit: off-chip receiver ready, from io_in.
REQ-010 SHALL have port pad_valid_o, output, 1 bit: beat valid to io_out.
REQ-011 SHALL have port pad_data_o, output, DATA_W bits: payload to io_out.
REQ-012 SHALL have port pad_last_o, output, 1 bit: end-of-frame to io_out.
REQ-013 SHALL have port flush_i, input, 1 bit: synchronous FIFO clear.
REQ-014 SHALL have port level_o, output, log2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port frame_cnt_o, output, 16 bits: completed frames delivered to pad.

Function
REQ-016 SHALL push {in_last, in_data} when in_valid && in_ready at a clock edge.
REQ-017 SHALL pop the head entry when pad_valid_o && pad_ready_i at a clock edge.
REQ-018 SHALL drive in_ready = (level_o != DEPTH) && !wb_rst_i && !flush_i, with no combinational path from pad_ready_i.
REQ-019 SHALL drive pad_valid_o = (level_o != 0), and pad_data_o/pad_last_o from head-entry storage flops only (no path from in_*).
REQ-020 SHALL give latency of exactly 1 cycle: a beat pushed into an empty FIFO at edge N is presented on pad_* after edge N.
REQ-021 SHALL support simultaneous push and pop when 0 < level < DEPTH, leaving level unchanged.
REQ-022 SHALL NOT push when full, even if a pop occurs in the same cycle (no full-bypass).
REQ-023 SHALL NOT pop when empty, and SHALL NOT bypass an input beat straight to the pad.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL hold pad_data_o/pad_last_o stable while pad_valid_o=1 and pad_ready_i=0.
REQ-026 SHALL increment frame_cnt_o by 1 on each pop with pad_last_o=1, wrapping 0xFFFF->0x0000.
REQ-027 SHALL, when flush_i=1, set level and pointers to 0 at the next edge, overriding any same-cycle push or pop.
REQ-028 SHALL leave frame_cnt_o unaffected by flush_i, except that a pop is suppressed during flush and is not counted.

Reset
REQ-029 SHALL, while wb_rst_i=1 at an edge, clear pointers, level_o, and frame_cnt_o to 0.
REQ-030 SHALL hold pad_valid_o=0 and in_ready=0 throughout reset; storage contents may be left uncleared.
REQ-031 SHALL apply reset asserted mid-frame identically to reset from idle; the partial frame is discarded and not counted.

Structure
REQ-032 SHALL place DATA_W default, DEPTH default, FRAME_CNT_W=16, and the {last, data} entry typedef in shared package stream_pad_pkg.
REQ-033 SHALL be implemented as a single module; no sub-module is required.

Verification
REQ-034 SHALL cover reset: assert wb_rst_i 3 cycles, then release -> pad_valid_o=0, level_o=0, frame_cnt_o=0, and in_ready=1 one cycle after release.
REQ-035 SHALL cover fill with pad_ready_i=0: push 0x0001..0x0004 -> in_ready=0 after the 4th push, level_o=4, pad_data_o=0x0001 held stable.
REQ-036 SHALL cover streaming with pad_ready_i=1: a continuous 8-beat frame 0x00A0..0x00A7 with last on beat 8 -> pad output in order, 1-cycle latency, frame_cnt_o=1, level_o<=1.
REQ-037 SHALL cover full plus pop: at level 4 with in_valid=1 and pad_ready_i=1 -> pop only, level_o=3; the push lands on the next cycle.
REQ-038 SHALL cover flush: at level 3, flush_i=1 together with push and pop -> level_o=0 and pad_valid_o=0 next cycle, frame_cnt_o unchanged.
REQ-039 SHALL cover frame-counter wrap: preload to 0xFFFF via 65535 single-beat frames (or force), send one more last beat -> frame_cnt_o=0x0000.

Source files
------------

// File: rtl/stream_pad_pkg.sv
// stream_pad_pkg: shared widths and entry type for the pad-side stream FIFO
package stream_pad_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int FRAME_CNT_W = 16;
  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/stream_pad_fifo.sv
// stream_pad_fifo: registered FIFO from the DSP stream to the IO pads with a completed-frame counter
module stream_pad_fifo
  import stream_pad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  input  logic                     pad_ready_i,
  output logic                     pad_valid_o,
  output logic [DATA_W-1:0]        pad_data_o,
  output logic                     pad_last_o,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [FRAME_CNT_W-1:0]   frame_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  assign in_ready    = (level_o != LW'(DEPTH)) && !wb_rst_i && !flush_i;
  assign pad_valid_o = (level_o != '0) && !wb_rst_i;
  assign pad_data_o  = mem[rd_ptr].data;
  assign pad_last_o  = mem[rd_ptr].last;
  assign push        = in_valid && in_ready;
  // flush wins over a same-cycle pop, so a flushed head is never counted
  assign pop         = pad_valid_o && pad_ready_i && !flush_i;
  always_ff @(posedge wb_clk_i)
    if (push) mem[wr_ptr] <= '{last: in_last, data: in_data};
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level_o <= level_o + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) frame_cnt_o <= '0;
    else if (pop && pad_last_o) frame_cnt_o <= frame_cnt_o + 1'b1;
  end
endmodule

// File: tb/tb_stream_pad_fifo.sv
// tb_stream_pad_fifo: directed checks of fill, streaming, full-pop, flush, reset and counter wrap
module tb_stream_pad_fifo;
  logic        clk = 0;
  logic        rst, in_valid, in_ready, in_last, pad_ready, pad_valid, pad_last, flush;
  logic [15:0] in_data, pad_data, frame_cnt;
  logic [2:0]  level;
  int          errors = 0, checks = 0;

  stream_pad_fifo dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .pad_ready_i(pad_ready),
    .pad_valid_o(pad_valid), .pad_data_o(pad_data), .pad_last_o(pad_last),
    .flush_i(flush), .level_o(level), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; pad_ready = 0; flush = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_valid", pad_valid, 0);
      chk("rst_ready", in_ready, 0);
    end
    chk("rst_level", level, 0);
    rst = 0;
    tick;
    chk("post_rst_level", level, 0);
    chk("post_rst_valid", pad_valid, 0);
    chk("post_rst_cnt", frame_cnt, 0);
    chk("post_rst_ready", in_ready, 1);

    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = 16'(i); in_last = 0;
      tick;
      chk("fill_level", level, i);
      chk("fill_head", pad_data, 16'h0001);
    end
    chk("fill_ready", in_ready, 0);
    in_valid = 0;
    tick;
    chk("hold_head", pad_data, 16'h0001);
    chk("hold_valid", pad_valid, 1);
    chk("hold_level", level, 4);

    in_valid = 1; in_data = 16'h0005; pad_ready = 1;
    tick;
    chk("fullpop_level", level, 3);
    chk("fullpop_head", pad_data, 16'h0002);
    pad_ready = 0;
    tick;
    chk("late_push_level", level, 4);
    chk("late_push_head", pad_data, 16'h0002);
    in_valid = 0; pad_ready = 1;
    tick;
    chk("pre_flush_level", level, 3);
    chk("pre_flush_head", pad_data, 16'h0003);

    flush = 1; in_valid = 1; in_data = 16'h0006; in_last = 1;
    #1;
    chk("flush_ready", in_ready, 0);
    tick;
    chk("flush_level", level, 0);
    chk("flush_valid", pad_valid, 0);
    chk("flush_cnt", frame_cnt, 0);
    flush = 0; in_valid = 0; in_last = 0;

    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_data = 16'h00A0 + 16'(k); in_last = (k == 7);
      tick;
      chk("stream_valid", pad_valid, 1);
      chk("stream_data", pad_data, 16'h00A0 + k);
      chk("stream_last", pad_last, k == 7);
      chk("stream_level", level, 1);
    end
    in_valid = 0; in_last = 0;
    tick;
    chk("stream_cnt", frame_cnt, 1);
    chk("stream_drained", level, 0);

    pad_ready = 0; in_valid = 1; in_data = 16'h0BB0; in_last = 0;
    tick;
    in_last = 1; in_data = 16'h0BB1;
    tick;
    in_valid = 0; pad_ready = 1; rst = 1;
    #1;
    chk("midrst_valid", pad_valid, 0);
    chk("midrst_ready", in_ready, 0);
    tick;
    rst = 0;
    tick;
    chk("midrst_level", level, 0);
    chk("midrst_cnt", frame_cnt, 0);
    chk("midrst_valid2", pad_valid, 0);

    in_valid = 1; in_last = 1;
    for (int n = 0; n < 65535; n++) begin
      in_data = 16'(n);
      tick;
    end
    in_valid = 0;
    tick;
    chk("wrap_pre_cnt", frame_cnt, 16'hFFFF);
    in_valid = 1; in_data = 16'hCAFE;
    tick;
    in_valid = 0;
    tick;
    chk("wrap_cnt", frame_cnt, 16'h0000);
    chk("wrap_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
